unid_escrita_mem: RTL and testbench
===================================

Name: unid_escrita_mem

Overview:
- Store-side narrowing unit for the data-memory port; the write-path counterpart of the load-side 16→32 sign extender.
- Accepts a 32-bit register value, an access size and a byte address from the MEM stage.
- Places the byte or halfword on the correct lanes with byte enables, then runs a req/ack write handshake to data memory.
- Reports completion, misalignment and bus timeout back to the pipeline.

Parameters:
- TIMEOUT, default 15: maximum cycles in REQ without mem_ack before the write is aborted (valid range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  store request from pipeline, sampled only in IDLE
- size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved
- addr  input  32  byte address of the store
- data  input  32  register value to store
- busy  output  1  high while a write is outstanding (state REQ); pipeline stalls on it
- done  output  1  one-cycle pulse, write accepted by memory
- err_align  output  1  one-cycle pulse, misaligned address or reserved size
- err_timeout  output  1  one-cycle pulse, no mem_ack within TIMEOUT cycles
- mem_req  output  1  write request to data memory
- mem_we  output  1  write enable; equals mem_req
- mem_addr  output  32  word address: {addr[31:2],2'b00}
- mem_wdata  output  32  lane-placed write data
- mem_be  output  4  byte enables, bit i selects mem_wdata[8i+7:8i] (little-endian)
- mem_ack  input  1  memory accepted the write this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including mem_addr, mem_wdata, mem_be and the timeout counter. A reset during REQ drops mem_req immediately; the transaction is lost and no pulse is issued.
- All outputs are registered. States: IDLE, REQ.
- IDLE, start=1, legal access → latch outputs; next cycle state=REQ, mem_req=mem_we=busy=1, counter=0.
- Lane placement:
  - byte: mem_wdata = {4{data[7:0]}}, mem_be = 4'b0001 << addr[1:0]
  - halfword: mem_wdata = {2{data[15:0]}}, mem_be = addr[1] ? 1100 : 0011
  - word: mem_wdata = data, mem_be = 1111
- Legality check:
  - Illegal cases: halfword with addr[0]=1; word with addr[1:0]≠00; size=11.
  - On an illegal start: no mem_req; err_align=1 next cycle for one cycle; state stays IDLE; mem_* outputs unchanged.
- REQ holds mem_addr, mem_wdata and mem_be stable until exit. Each REQ cycle without ack increments the counter.
- Exit by acknowledge: mem_ack=1 in REQ → next cycle IDLE, mem_req=busy=0, done=1 for one cycle. Zero-wait ack gives done 2 cycles after start.
- Exit by timeout: counter==TIMEOUT-1 with mem_ack=0 → next cycle IDLE, mem_req=busy=0, err_timeout=1 for one cycle.
- Ack and timeout on the same cycle: ack wins; done=1, err_timeout=0.
- start while in REQ is ignored (the pipeline is stalled by busy). start is accepted in IDLE on the same cycle done or an error pulse is high (back-to-back stores).
- mem_ack while in IDLE is ignored.
- At most one of done, err_align, err_timeout is high in any cycle.

Test Plan:
- Reset, then idle 3 cycles → all outputs 0; busy=0, mem_req=0.
- Byte store: start, size=00, addr=0x00000102, data=0x123456AB; ack 1 cycle after req rises → mem_addr=0x00000100, mem_wdata=0xABABABAB, mem_be=0100; done pulses once; busy high exactly 1 cycle.
- Halfword and word stores:
  - Halfword, addr=0x00000206, data=0xFFFF8001 → mem_wdata=0x80018001, mem_be=1100.
  - Word, addr=0x00000010, data=0xDEADBEEF → mem_be=1111, mem_wdata=0xDEADBEEF.
  - Ack delayed 4 cycles → outputs stable throughout, done 1 cycle after ack.
- Misalignment: halfword to addr=0x00000003, and size=11 to addr=0x0 → err_align pulse 1 cycle after start; mem_req never rises.
- Timeout: TIMEOUT=15, no ack → mem_req high exactly 15 cycles, then err_timeout pulse. Repeat with ack on the 15th REQ cycle → done, no err_timeout.
- Assert rst_n=0 mid-REQ → mem_req falls without waiting for a clock edge. Then a back-to-back byte store issued on the done cycle → accepted; second mem_req rises the next cycle.

Source files
------------

// File: rtl/unid_escrita_mem.sv
// unid_escrita_mem: store-side lane placement and req/ack write handshake to data memory
module unid_escrita_mem #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [7:0] cnt;
  logic legal;
  logic [31:0] wdata;
  logic [3:0] be;
  always_comb begin
    legal = size == 2'b00 || (size == 2'b01 && !addr[0]) || (size == 2'b10 && addr[1:0] == 2'b00);
    wdata = size == 2'b00 ? {4{data[7:0]}} : size == 2'b01 ? {2{data[15:0]}} : data;
    be    = size == 2'b00 ? 4'b0001 << addr[1:0] : size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  assign mem_we = mem_req;
  // ack is tested before the timeout so it wins when both land on the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
    end else begin
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (legal) begin
            state     <= REQ;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            cnt       <= '0;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
            mem_be    <= be;
          end else
            err_align <= 1'b1;
        end
        REQ: if (mem_ack || cnt == 8'(TIMEOUT - 1)) begin
          state       <= IDLE;
          busy        <= 1'b0;
          mem_req     <= 1'b0;
          done        <= mem_ack;
          err_timeout <= !mem_ack;
        end else
          cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unid_escrita_mem.sv
// tb_unid_escrita_mem: scenario tasks plus a scoreboard monitor checking each memory write request
module tb_unid_escrita_mem;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ack = 1'b0;
  logic [1:0] size = '0;
  logic [31:0] addr = '0, data = '0;
  logic busy, done, err_align, err_timeout, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;

  typedef struct {logic [31:0] a; logic [31:0] w; logic [3:0] be;} txn_t;
  txn_t sb[$];
  txn_t cur;
  logic req_q = 1'b0;

  unid_escrita_mem #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .addr(addr), .data(data),
    .busy(busy), .done(done), .err_align(err_align), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // a new request pops the scoreboard; while it stays up the bus must hold that transaction
  always @(negedge clk) begin
    if (mem_req !== mem_we) begin
      checks++; errors++;
      $display("FAIL we_eq_req: mem_we=%b mem_req=%b", mem_we, mem_req);
    end
    if (mem_req && !req_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: mem_req rose with nothing expected, addr=%h", mem_addr);
      end else begin
        cur = sb.pop_front();
        if ({mem_addr, mem_wdata, mem_be} !== {cur.a, cur.w, cur.be}) begin
          errors++;
          $display("FAIL req_payload: got addr=%h wdata=%h be=%b, want addr=%h wdata=%h be=%b",
                   mem_addr, mem_wdata, mem_be, cur.a, cur.w, cur.be);
        end
      end
    end else if (mem_req) begin
      checks++;
      if ({mem_addr, mem_wdata, mem_be} !== {cur.a, cur.w, cur.be}) begin
        errors++;
        $display("FAIL req_stable: got addr=%h wdata=%h be=%b, want addr=%h wdata=%h be=%b",
                 mem_addr, mem_wdata, mem_be, cur.a, cur.w, cur.be);
      end
    end
    req_q <= mem_req;
  end

  // called on a negedge; returns on the next negedge with start released
  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    logic ok;
    ok = sz == 2'd0 || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a[1:0] == 2'd0);
    t.a = {a[31:2], 2'b00};
    t.be = 4'b0000;
    case (sz)
      2'd0: begin t.w = {d[7:0], d[7:0], d[7:0], d[7:0]}; t.be[a[1:0]] = 1'b1; end
      2'd1: begin t.w = {d[15:0], d[15:0]}; t.be = a[1] ? 4'hC : 4'h3; end
      default: begin t.w = d; t.be = 4'hF; end
    endcase
    if (ok) sb.push_back(t);
    start = 1'b1; size = sz; addr = a; data = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err_align, err_timeout, mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b ea=%b et=%b req=%b addr=%h wdata=%h be=%b, want all 0",
               busy, done, err_align, err_timeout, mem_req, mem_addr, mem_wdata, mem_be);
    end
  endtask

  task automatic test_store(input string nm, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input int wait_cyc, input logic [31:0] ew,
                            input logic [3:0] ebe);
    send(sz, a, d);
    checks++;
    if ({busy, mem_req, mem_wdata, mem_be, mem_addr} !== {2'b11, ew, ebe, a[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s_lanes: busy=%b req=%b wdata=%h be=%b addr=%h, want 1 1 %h %b %h",
               nm, busy, mem_req, mem_wdata, mem_be, mem_addr, ew, ebe, {a[31:2], 2'b00});
    end
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_req, done} !== 3'b110) begin
        errors++;
        $display("FAIL %s_wait: busy=%b req=%b done=%b, want 1 1 0", nm, busy, mem_req, done);
      end
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({done, busy, mem_req, err_timeout} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b req=%b et=%b, want 1 0 0 0", nm, done, busy, mem_req, err_timeout);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b, want 0", nm, done);
    end
  endtask

  task automatic test_align(input string nm, input logic [1:0] sz, input logic [31:0] a);
    send(sz, a, 32'hFFFF_FFFF);
    checks++;
    if ({err_align, mem_req, busy, mem_addr, mem_be} !== {3'b100, 32'h10, 4'hF}) begin
      errors++;
      $display("FAIL %s_err: ea=%b req=%b busy=%b addr=%h be=%b, want 1 0 0 00000010 1111",
               nm, err_align, mem_req, busy, mem_addr, mem_be);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({err_align, mem_req, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s_pulse: ea=%b req=%b done=%b, want 0 0 0", nm, err_align, mem_req, done);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    send(2'd0, 32'h20, 32'h55);
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 15 || {err_timeout, done, busy} !== 3'b100) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d et=%b done=%b busy=%b, want 15 1 0 0", n, err_timeout, done, busy);
    end
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: et=%b, want 0", err_timeout);
    end
    send(2'd1, 32'h22, 32'h1234);
    repeat (14) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_last_cycle: req=%b, want 1", mem_req);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({done, err_timeout, mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL ack_beats_timeout: done=%b et=%b req=%b, want 1 0 0", done, err_timeout, mem_req);
    end
  endtask

  task automatic test_reset_mid_req();
    send(2'd2, 32'h40, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, mem_addr} !== 34'b0) begin
      errors++;
      $display("FAIL async_reset: req=%b busy=%b addr=%h, want 0 0 0", mem_req, busy, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, err_timeout, err_align, mem_req} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_no_pulse: done=%b et=%b ea=%b req=%b, want 0", done, err_timeout, err_align, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    send(2'd2, 32'h80, 32'h1122_3344);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b, want 1", done);
    end
    send(2'd0, 32'h81, 32'h0000_00A5);
    checks++;
    if ({done, mem_req, busy, mem_be, mem_wdata} !== {3'b011, 4'b0010, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL b2b_second_req: done=%b req=%b busy=%b be=%b wdata=%h, want 0 1 1 0010 a5a5a5a5",
               done, mem_req, busy, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({done, mem_req} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b req=%b, want 1 0", done, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_store("byte", 2'd0, 32'h102, 32'h1234_56AB, 0, 32'hABAB_ABAB, 4'b0100);
    test_store("half", 2'd1, 32'h206, 32'hFFFF_8001, 0, 32'h8001_8001, 4'b1100);
    test_store("word", 2'd2, 32'h10, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 4'b1111);
    test_align("half_odd", 2'd1, 32'h3);
    test_align("size11", 2'd3, 32'h0);
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected requests never seen, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
